// File: rtl/dca_req_buffer.sv
// dca_req_buffer: in-order request FIFO with a credit limit and a credit-sized response FIFO in front of the DCA lane fork.
// Optional macro DCA_REQ_BUFFER_STALL_CNT_EN adds a saturating credit-stall counter on stall_cnt_o.

module dca_req_buffer_fifo #(
    parameter int Width = 8,
    parameter int Depth = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] din,
    input  logic             pop,
    output logic [Width-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr;
    logic [PtrW-1:0]  rptr;
    logic [CntW-1:0]  count;
    logic             wr;
    logic             rd;

    assign wr    = push & ~full;
    assign rd    = pop & ~empty;
    assign empty = (count == '0);
    assign full  = (count == CntW'(Depth));
    assign dout  = mem[rptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) wptr <= (wptr == LastPtr) ? '0 : wptr + 1'b1;
            if (rd) rptr <= (rptr == LastPtr) ? '0 : rptr + 1'b1;
            case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only observed once written.
    always_ff @(posedge clk_i) begin
        if (wr) mem[wptr] <= din;
    end
endmodule

// Port vectors are the packed structs, MSB first:
//   dca_req_t = {q_valid, q{rnd_mode[2:0], op[3:0], op_mod, src_fmt[2:0], dst_fmt[2:0], int_fmt[1:0], vectorial_op, operands[2:0]}, p_ready}
//   dca_rsp_t = {q_ready, p_valid, p{result[DataWidth-1:0], status[4:0]}}
module dca_req_buffer #(
    parameter int DataWidth      = 512,
    parameter int ReqDepth       = 2,
    parameter int MaxOutstanding = 4,
    parameter int CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [3*DataWidth+18:0] slv_req_i,
    output logic [DataWidth+6:0]    slv_rsp_o,
    output logic [3*DataWidth+18:0] mst_req_o,
    input  logic [DataWidth+6:0]    mst_rsp_i,
    output logic                    busy_o,
    output logic [31:0]             stall_cnt_o
);
    localparam int QW = 3*DataWidth + 17;
    localparam int PW = DataWidth + 5;
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    logic          slv_q_valid;
    logic [QW-1:0] slv_q;
    logic          slv_p_ready;
    logic          mst_q_ready;
    logic          mst_p_valid;
    logic [PW-1:0] mst_p;

    assign slv_q_valid = slv_req_i[QW+1];
    assign slv_q       = slv_req_i[QW:1];
    assign slv_p_ready = slv_req_i[0];
    assign mst_q_ready = mst_rsp_i[PW+1];
    assign mst_p_valid = mst_rsp_i[PW];
    assign mst_p       = mst_rsp_i[PW-1:0];

    logic [CntWidth-1:0] cnt;
    logic [QW-1:0]       req_head;
    logic [PW-1:0]       rsp_head;
    logic                req_empty;
    logic                req_full;
    logic                rsp_empty;
    logic                rsp_full;

    logic          q_ready;
    logic          m_q_valid;
    logic          m_p_ready;
    logic          s_p_valid;
    logic          slv_q_hs;
    logic          slv_p_hs;
    logic          mst_q_hs;
    logic          mst_p_hs;

    // Every handshake term carries !rst_i so nothing completes while reset is high.
    assign q_ready   = ~rst_i & ~req_full & (cnt < MaxCnt);
    assign m_q_valid = ~rst_i & ~req_empty;
    assign m_p_ready = ~rst_i & ~rsp_full;
    assign s_p_valid = ~rst_i & ~rsp_empty;

    assign slv_q_hs = slv_q_valid & q_ready;
    assign slv_p_hs = s_p_valid & slv_p_ready;
    assign mst_q_hs = m_q_valid & mst_q_ready;
    assign mst_p_hs = mst_p_valid & m_p_ready;

    dca_req_buffer_fifo #(
        .Width (QW),
        .Depth (ReqDepth)
    ) i_req_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (slv_q_hs),
        .din   (slv_q),
        .pop   (mst_q_hs),
        .dout  (req_head),
        .empty (req_empty),
        .full  (req_full)
    );

    dca_req_buffer_fifo #(
        .Width (PW),
        .Depth (MaxOutstanding)
    ) i_rsp_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (mst_p_hs),
        .din   (mst_p),
        .pop   (slv_p_hs),
        .dout  (rsp_head),
        .empty (rsp_empty),
        .full  (rsp_full)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else begin
            case ({slv_q_hs, slv_p_hs})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payloads are forced to zero when their valid is low, which also covers reset.
    assign mst_req_o = {m_q_valid, (m_q_valid ? req_head : {QW{1'b0}}), m_p_ready};
    assign slv_rsp_o = {q_ready, s_p_valid, (s_p_valid ? rsp_head : {PW{1'b0}})};
    assign busy_o    = ~rst_i & (cnt != '0);

`ifdef DCA_REQ_BUFFER_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt <= '0;
        end else if (slv_q_valid && (cnt == MaxCnt) && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = rst_i ? 32'h0 : stall_cnt;
`else
    assign stall_cnt_o = 32'h0;
`endif

    a_cnt_underflow : assert property (@(posedge clk_i) disable iff (rst_i)
        !(slv_p_hs && !slv_q_hs && (cnt == '0)));
    a_cnt_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
        cnt <= MaxCnt);
    a_rsp_overrun : assert property (@(posedge clk_i) disable iff (rst_i)
        !(mst_p_valid && rsp_full));
    a_mst_q_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (m_q_valid && !mst_q_ready) |=> (m_q_valid && $stable(req_head)));
endmodule

// File: tb/tb_dca_req_buffer.sv
// Directed/table-driven bench for dca_req_buffer plus a 1000-transaction scoreboard run.
// Builds with or without DCA_REQ_BUFFER_STALL_CNT_EN; the stall counter expectation follows the macro.

module tb_dca_req_buffer;
    localparam int DW = 512;

    typedef struct packed {
        logic [2:0]          rnd_mode;
        logic [3:0]          op;
        logic                op_mod;
        logic [2:0]          src_fmt;
        logic [2:0]          dst_fmt;
        logic [1:0]          int_fmt;
        logic                vectorial_op;
        logic [2:0][DW-1:0]  operands;
    } q_t;
    typedef struct packed { logic [DW-1:0] result; logic [4:0] status; } p_t;
    typedef struct packed { logic q_valid; q_t q; logic p_ready; } req_t;
    typedef struct packed { logic q_ready; logic p_valid; p_t p; } rsp_t;

    typedef struct {
        logic rst, sqv, spr, mqr, mpv;
        logic e_sqr, e_spv, e_mqv, e_mpr, e_busy;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    req_t        s_req;
    req_t        m_req;
    rsp_t        s_rsp;
    rsp_t        m_rsp;
    logic        busy;
    logic [31:0] stall_cnt;

    int errors = 0;
    int checks = 0;
    q_t add_q;
    p_t ret_p;
    vec_t tbl[10];

    always #5 clk = ~clk;

    dca_req_buffer #(
        .DataWidth      (DW),
        .ReqDepth       (2),
        .MaxOutstanding (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .slv_req_i   (s_req),
        .slv_rsp_o   (s_rsp),
        .mst_req_o   (m_req),
        .mst_rsp_i   (m_rsp),
        .busy_o      (busy),
        .stall_cnt_o (stall_cnt)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk_n(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input q_t act, input q_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got op=%0h opnd0=%0h expected op=%0h opnd0=%0h",
                     name, act.op, act.operands[0][63:0], exp.op, exp.operands[0][63:0]);
        end
    endtask

    task automatic chk_p(input string name, input p_t act, input p_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got result=%0h status=%0h expected result=%0h status=%0h",
                     name, act.result[63:0], act.status, exp.result[63:0], exp.status);
        end
    endtask

    function automatic vec_t mkv(input logic [9:0] b);
        vec_t v;
        {v.rst, v.sqv, v.spr, v.mqr, v.mpv, v.e_sqr, v.e_spv, v.e_mqv, v.e_mpr, v.e_busy} = b;
        return v;
    endfunction

    function automatic q_t mk_q(input int tag);
        q_t q;
        q = '0;
        q.op          = 4'd2;
        q.rnd_mode    = 3'(tag);
        q.operands[0] = DW'(tag);
        q.operands[1] = DW'(tag * 3 + 1);
        q.operands[2] = ~DW'(tag);
        return q;
    endfunction

    function automatic q_t rnd_q();
        q_t q;
        q.rnd_mode     = 3'($urandom_range(0, 7));
        q.op           = 4'($urandom_range(0, 15));
        q.op_mod       = 1'($urandom_range(0, 1));
        q.src_fmt      = 3'($urandom_range(0, 7));
        q.dst_fmt      = 3'($urandom_range(0, 7));
        q.int_fmt      = 2'($urandom_range(0, 3));
        q.vectorial_op = 1'($urandom_range(0, 1));
        for (int o = 0; o < 3; o++)
            for (int w = 0; w < DW / 32; w++)
                q.operands[o][w*32 +: 32] = $urandom;
        return q;
    endfunction

    // Fork model: any deterministic function of the request will do.
    function automatic p_t fork_resp(input q_t q);
        p_t p;
        p.result = (q.operands[0] + q.operands[1]) ^ q.operands[2];
        p.status = {q.op_mod, q.op};
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_req = '0;
        m_rsp = '0;
    endtask

    task automatic do_reset();
        step();
        idle_inputs();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    initial begin
        int acc;
        int issued;
        int done;
        int cyc;
        logic q_acc;
        q_t exp_mq[$];
        p_t exp_sp[$];
        q_t fork_pend[$];

        idle_inputs();
        add_q             = '0;
        add_q.op          = 4'd2;
        add_q.operands[0] = DW'(1);
        ret_p.result      = DW'(2);
        ret_p.status      = 5'h01;

        // columns: rst sqv spr mqr mpv | q_ready p_valid(slv) q_valid(mst) p_ready(mst) busy
        tbl[0] = mkv(10'b11010_00000);
        tbl[1] = mkv(10'b11010_00000);
        tbl[2] = mkv(10'b11010_00000);
        tbl[3] = mkv(10'b00000_10010);
        tbl[4] = mkv(10'b01000_10010);
        tbl[5] = mkv(10'b00010_10111);
        tbl[6] = mkv(10'b00000_10011);
        tbl[7] = mkv(10'b00001_10011);
        tbl[8] = mkv(10'b00100_11011);
        tbl[9] = mkv(10'b00000_10010);

        step();
        for (int i = 0; i < 10; i++) begin
            rst           = tbl[i].rst;
            s_req.q_valid = tbl[i].sqv;
            s_req.q       = add_q;
            s_req.p_ready = tbl[i].spr;
            m_rsp.q_ready = tbl[i].mqr;
            m_rsp.p_valid = tbl[i].mpv;
            m_rsp.p       = tbl[i].mpv ? ret_p : '0;
            @(negedge clk);
            chk_b($sformatf("tbl[%0d].q_ready", i), s_rsp.q_ready, tbl[i].e_sqr);
            chk_b($sformatf("tbl[%0d].slv_p_valid", i), s_rsp.p_valid, tbl[i].e_spv);
            chk_b($sformatf("tbl[%0d].mst_q_valid", i), m_req.q_valid, tbl[i].e_mqv);
            chk_b($sformatf("tbl[%0d].mst_p_ready", i), m_req.p_ready, tbl[i].e_mpr);
            chk_b($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
            if (tbl[i].rst) begin
                chk_q($sformatf("tbl[%0d].mst_q_zero", i), m_req.q, '0);
                chk_p($sformatf("tbl[%0d].slv_p_zero", i), s_rsp.p, '0);
                chk_n($sformatf("tbl[%0d].stall_zero", i), stall_cnt, 0);
            end
            if (tbl[i].e_mqv) chk_q($sformatf("tbl[%0d].mst_q", i), m_req.q, add_q);
            if (tbl[i].e_spv) chk_p($sformatf("tbl[%0d].slv_p", i), s_rsp.p, ret_p);
            step();
        end

        // Credit limit: 4 accepts, then 10 credit-stall cycles.
        do_reset();
        acc = 0;
        for (int c = 0; c < 14; c++) begin
            s_req.q_valid = 1'b1;
            s_req.q       = mk_q(acc);
            m_rsp.q_ready = 1'b1;
            @(negedge clk);
            if (s_rsp.q_ready) acc++;
            step();
        end
        s_req.q_valid = 1'b0;
        m_rsp.p_valid = 1'b1;
        m_rsp.p       = fork_resp(mk_q(0));
        @(negedge clk);
        chk_n("credit.accepted", acc, 4);
        chk_b("credit.q_ready_low", s_rsp.q_ready, 1'b0);
        chk_b("credit.busy", busy, 1'b1);
        chk_b("credit.mst_p_ready", m_req.p_ready, 1'b1);
`ifdef DCA_REQ_BUFFER_STALL_CNT_EN
        chk_n("credit.stall_cnt", stall_cnt, 10);
`else
        chk_n("credit.stall_cnt", stall_cnt, 0);
`endif
        step();
        m_rsp.p_valid = 1'b0;
        m_rsp.p       = '0;
        s_req.p_ready = 1'b1;
        @(negedge clk);
        chk_b("credit.rsp_valid", s_rsp.p_valid, 1'b1);
        chk_p("credit.rsp_data", s_rsp.p, fork_resp(mk_q(0)));
        chk_b("credit.q_ready_same_cycle", s_rsp.q_ready, 1'b0);
        step();
        s_req.p_ready = 1'b0;
        @(negedge clk);
        chk_b("credit.q_ready_back", s_rsp.q_ready, 1'b1);
        chk_b("credit.busy_still", busy, 1'b1);

        // Back-pressure at both ends: 4 responses absorbed, then drained in order.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            s_req.q_valid = 1'b1;
            s_req.q       = mk_q(10 + c);
            m_rsp.q_ready = 1'b1;
            @(negedge clk);
            chk_b($sformatf("bp.q_ready[%0d]", c), s_rsp.q_ready, 1'b1);
            step();
        end
        s_req.q_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_rsp.p_valid = 1'b1;
            m_rsp.p       = fork_resp(mk_q(10 + k));
            @(negedge clk);
            chk_b($sformatf("bp.mst_p_ready[%0d]", k), m_req.p_ready, 1'b1);
            step();
        end
        m_rsp.p_valid = 1'b0;
        m_rsp.p       = '0;
        @(negedge clk);
        chk_b("bp.held_p_valid", s_rsp.p_valid, 1'b1);
        chk_b("bp.no_credit", s_rsp.q_ready, 1'b0);
        step();
        for (int k = 0; k < 4; k++) begin
            s_req.p_ready = 1'b1;
            @(negedge clk);
            chk_b($sformatf("bp.out_valid[%0d]", k), s_rsp.p_valid, 1'b1);
            chk_p($sformatf("bp.out_data[%0d]", k), s_rsp.p, fork_resp(mk_q(10 + k)));
            step();
        end
        s_req.p_ready = 1'b0;
        @(negedge clk);
        chk_b("bp.drained_valid", s_rsp.p_valid, 1'b0);
        chk_b("bp.drained_busy", busy, 1'b0);

        // Simultaneous q and p handshakes at cnt=2 leave cnt at 2.
        do_reset();
        m_rsp.q_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            s_req.q_valid = 1'b1;
            s_req.q       = mk_q(20 + c);
            step();
        end
        s_req.q_valid = 1'b0;
        m_rsp.p_valid = 1'b1;
        m_rsp.p       = fork_resp(mk_q(20));
        step();
        m_rsp.p_valid = 1'b0;
        m_rsp.p       = '0;
        s_req.q_valid = 1'b1;
        s_req.q       = mk_q(22);
        s_req.p_ready = 1'b1;
        @(negedge clk);
        chk_b("sim.q_ready", s_rsp.q_ready, 1'b1);
        chk_b("sim.p_valid", s_rsp.p_valid, 1'b1);
        chk_p("sim.p_data", s_rsp.p, fork_resp(mk_q(20)));
        step();
        s_req.p_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            s_req.q_valid = 1'b1;
            s_req.q       = mk_q(23 + acc);
            @(negedge clk);
            if (s_rsp.q_ready) acc++;
            step();
        end
        s_req.q_valid = 1'b0;
        chk_n("sim.extra_accepts", acc, 2);
        for (int k = 0; k < 4; k++) begin
            m_rsp.p_valid = 1'b1;
            m_rsp.p       = fork_resp(mk_q(21 + k));
            step();
        end
        m_rsp.p_valid = 1'b0;
        m_rsp.p       = '0;
        for (int k = 0; k < 4; k++) begin
            s_req.p_ready = 1'b1;
            @(negedge clk);
            chk_b($sformatf("sim.out_valid[%0d]", k), s_rsp.p_valid, 1'b1);
            chk_p($sformatf("sim.out_data[%0d]", k), s_rsp.p, fork_resp(mk_q(21 + k)));
            step();
        end
        s_req.p_ready = 1'b0;
        @(negedge clk);
        chk_b("sim.no_dup", s_rsp.p_valid, 1'b0);
        chk_b("sim.idle", busy, 1'b0);

        // Random traffic against an in-order scoreboard.
        do_reset();
        issued = 0;
        done   = 0;
        cyc    = 0;
        q_acc  = 1'b0;
        while (done < 1000 && cyc < 20000) begin
            if (q_acc) s_req.q_valid = 1'b0;
            if (!s_req.q_valid && issued < 1000 && $urandom_range(0, 3) != 0) begin
                s_req.q_valid = 1'b1;
                s_req.q       = rnd_q();
            end
            s_req.p_ready = ($urandom_range(0, 3) != 0);
            m_rsp.q_ready = ($urandom_range(0, 3) != 0);
            if (fork_pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                m_rsp.p_valid = 1'b1;
                m_rsp.p       = fork_resp(fork_pend[0]);
            end else begin
                m_rsp.p_valid = 1'b0;
                m_rsp.p       = '0;
            end
            @(negedge clk);
            q_acc = s_req.q_valid && s_rsp.q_ready;
            if (q_acc) begin
                exp_mq.push_back(s_req.q);
                exp_sp.push_back(fork_resp(s_req.q));
                issued++;
            end
            if (m_req.q_valid && m_rsp.q_ready) begin
                if (exp_mq.size() == 0) chk_n("rnd.mst_q_unexpected", 1, 0);
                else chk_q("rnd.mst_q", m_req.q, exp_mq.pop_front());
                fork_pend.push_back(m_req.q);
            end
            if (m_rsp.p_valid) begin
                chk_b("rnd.mst_p_ready", m_req.p_ready, 1'b1);
                if (m_req.p_ready) void'(fork_pend.pop_front());
            end
            if (s_rsp.p_valid && s_req.p_ready) begin
                if (exp_sp.size() == 0) chk_n("rnd.slv_p_unexpected", 1, 0);
                else chk_p("rnd.slv_p", s_rsp.p, exp_sp.pop_front());
                done++;
            end
            cyc++;
            step();
        end
        chk_n("rnd.completed", done, 1000);
        idle_inputs();
        @(negedge clk);
        chk_b("rnd.final_busy", busy, 1'b0);
`ifndef DCA_REQ_BUFFER_STALL_CNT_EN
        chk_n("rnd.stall_cnt_tied", stall_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dca_req_buffer.md
Name: dca_req_buffer

Overview:
- Decoupling and credit stage that sits directly upstream of the DCA lane fork, between the wide DCA master (core/accelerator port) and the fork's slave port.
- Buffers wide DCA requests in an in-order FIFO and limits in-flight transactions with a credit counter.
- Holds a response FIFO sized to the credit limit, so responses returned by the fork are always absorbed and never back-pressure the lanes.

Parameters:
- DataWidth, 512, width of operand/result fields in dca_req_t/dca_rsp_t (LaneDataWidth*NumLanes of the fork).
- ReqDepth, 2, request FIFO entries (>=1).
- MaxOutstanding, 4, maximum accepted-but-not-yet-returned transactions (>=1); also the response FIFO depth.
- CntWidth, $clog2(MaxOutstanding+1), derived, outstanding counter width.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  synchronous active-high reset.
- slv_req_i  in  dca_req_t  upstream request: q_valid, q{rnd_mode, op, op_mod, src_fmt, dst_fmt, int_fmt, vectorial_op, operands[2:0]}, p_ready.
- slv_rsp_o  out  dca_rsp_t  upstream response: q_ready, p_valid, p{result, status}.
- mst_req_o  out  dca_req_t  request toward fork.
- mst_rsp_i  in  dca_rsp_t  response from fork.
- busy_o  out  1  high while outstanding count != 0.
- stall_cnt_o  out  32  credit-stall cycle counter (see Optional Feature).

Behaviour:
- Reset: the clock is clk_i. The reset is synchronous and active-high on rst_i. While rst_i is high, all of the following are held:
  - slv_rsp_o.q_ready=0, slv_rsp_o.p_valid=0, slv_rsp_o.p='0.
  - mst_req_o.q_valid=0, mst_req_o.p_ready=0, mst_req_o.q='0.
  - busy_o=0, stall_cnt_o=0.
  - Both FIFOs are empty and the outstanding counter is 0.
  - Reset asserted mid-operation discards all buffered requests and responses. No handshake completes in a cycle with rst_i high.
- Outstanding counter (cnt):
  - +1 on an upstream q handshake (slv q_valid & q_ready).
  - -1 on an upstream p handshake (slv p_valid & p_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds MaxOutstanding and never wraps below 0. Underflow is a checked assertion.
- Request accept: slv_rsp_o.q_ready = !req_full & (cnt < MaxOutstanding).
  - The ready is combinational from state only and does not depend on q_valid.
  - An accepted request is pushed into the request FIFO.
- Request issue:
  - mst_req_o.q_valid = !req_empty; mst_req_o.q = FIFO head. Pop on mst q_valid & mst_rsp_i.q_ready.
  - No fall-through: a request accepted in cycle N is visible at the master side at the earliest in cycle N+1.
  - Head contents stay stable while q_valid=1 and the request is not accepted (AXI-style valid stability).
  - Push and pop in the same cycle on a full FIFO is not possible, because q_ready=0 when full. On a non-empty, non-full FIFO it is allowed and occupancy stays unchanged.
- Response path:
  - mst_req_o.p_ready = !rsp_full. Since cnt <= MaxOutstanding equals the depth, this is 1 whenever out of reset.
  - mst_rsp_i.p_valid while rsp_full is an assertion error.
  - The response {result, status} is pushed on mst p handshake.
  - slv_rsp_o.p_valid = !rsp_empty; slv_rsp_o.p = head; pop on slv p_ready. Minimum latency is 1 cycle, with no fall-through.
- Ordering: strictly in order. Responses return in request order; no IDs.
- Throughput: 1 request/cycle and 1 response/cycle sustained when not credit-limited. The round trip through the block is at least 2 cycles plus the fork/lane latency.
- busy_o = (cnt != 0), registered from counter state.

Optional Feature:
- Macro DCA_REQ_BUFFER_STALL_CNT_EN.
- Defined: stall_cnt_o is a 32-bit register.
  - Cleared on reset.
  - Increments on each cycle with slv_req_i.q_valid=1 and slv_rsp_o.q_ready=0 because cnt==MaxOutstanding. FIFO-full stalls with credits available are not counted.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: stall_cnt_o tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Reset: hold rst_i high 3 cycles with slv q_valid=1 -> q_ready=0, busy_o=0, no mst q_valid. Deassert -> q_ready=1 next cycle.
- Single transaction (defaults): push op=ADD with operands[0]=512'h1 in cycle 0.
  - mst q_valid rises in cycle 1.
  - Fork returns result=512'h2, status=5'h01 in cycle 3 -> slv p_valid in cycle 4 with the same data.
  - busy_o is high from cycle 1 to cycle 4, then 0.
- Credit limit: mst_rsp_i.q_ready=1, mst p_valid withheld, slv q_valid held high.
  - Exactly 4 requests accepted, then q_ready=0 and busy_o=1.
  - Return one response and pop it -> q_ready=1 the cycle after the upstream p handshake.
- Back-pressure both ends: slv p_ready=0 and fork returns 4 responses -> all absorbed (mst p_ready stays 1) and they exit in order 0..3 once slv p_ready=1.
- Simultaneous events: with cnt=2, a q handshake and a p handshake in the same cycle -> cnt stays 2 and no data is lost or duplicated. Random 1000-transaction run: scoreboard checks order and data.
- Stall counter (macro on): saturate credits and hold q_valid for 10 cycles -> stall_cnt_o=10. Macro off -> stall_cnt_o=0 throughout.
